uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART TX shift register between several byte sources (accumulator result, RX echo, status).
//  Round-robin arbitration picks one pending requester, captures its byte, then sequences the external 10-bit
//  TX shifter (start + 8 data LSB-first + stop) with tx_load/tx_shift pulses at the baud rate. One frame at a time.
// PARAMETERS
//  NUM_REQ       3     number of requesters, legal 2..4
//  CLKS_PER_BIT  5208  CLOCK_50 cycles per UART bit (9600 baud); legal >= 2
// PORTS
//  CLOCK_50   in   1            system clock, all logic on rising edge
//  reset_n    in   1            asynchronous, active-low reset
//  tx_en      in   1            1 = new grants allowed; 0 = hold off (in-flight frame completes)
//  req        in   NUM_REQ      req[i]=1: requester i has a byte; held until ack[i]
//  req_data   in   NUM_REQ*8    byte of requester i at [8*i+7:8*i]
//  ack        out  NUM_REQ      one-cycle pulse: requester i's byte captured; may drop req/change data next cycle
//  tx_data    out  8            captured byte to the shifter; stable from LOAD until next LOAD
//  tx_load    out  1            one-cycle pulse: shifter parallel-loads {1'b1, tx_data, 1'b0}
//  tx_shift   out  1            one-cycle pulse at end of each bit period: shifter shifts right, fills 1
//  busy       out  1            1 while a frame is in LOAD or SEND
//  grant_id   out  2            index of requester owning current/last frame
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; ack=0, tx_load=0, tx_shift=0, busy=0, tx_data=8'h00, grant_id=0;
//   baud/bit counters 0; RR pointer last=NUM_REQ-1 (so req[0] wins first). Takes effect immediately, no clock.
//  FSM states: IDLE, LOAD, SEND.
//  IDLE: if tx_en=1 and |req: winner = first i with req[i]=1 searching last+1, last+2, ... (mod NUM_REQ);
//   register tx_data<=req_data[winner], grant_id<=winner, last<=winner; go LOAD. Else stay IDLE.
//  LOAD (exactly 1 cycle): tx_load=1, ack[grant_id]=1, busy=1; clear baud_cnt, bit_cnt; go SEND.
//  SEND: busy=1; baud_cnt counts 0..CLKS_PER_BIT-1; at terminal count: tx_shift=1, baud_cnt<=0, bit_cnt++.
//   On the 10th tx_shift pulse go IDLE. No ack/tx_load in SEND.
//  Timing: LOAD at t0; tx_shift at t0+k*CLKS_PER_BIT, k=1..10; IDLE at t0+10*CLKS_PER_BIT+1;
//   busy high for 10*CLKS_PER_BIT+1 cycles. Back-to-back frames: next LOAD at t0+10*CLKS_PER_BIT+2 (1 IDLE cycle).
//  Only one of ack bits high at any cycle; ack and tx_load always coincide; tx_load and tx_shift never coincide.
//  Requests are level; a req dropped before grant is withdrawn: no ack, no frame.
//  req held after its ack is a new request; RR pointer ensures others are served first if pending.
//  req[i] with i >= NUM_REQ: n/a. req_data of non-winners ignored; req_data change during SEND has no effect.
//  tx_en=0 during LOAD/SEND: frame completes normally; no new grant until tx_en=1 in IDLE.
//  Reset mid-frame: frame aborted (remaining tx_shift pulses not issued), no ack re-issued; shifter reset by owner.
//  Counter widths: baud_cnt $clog2(CLKS_PER_BIT) bits, bit_cnt 4 bits; no wrap beyond 10.
// TESTING (bench with CLKS_PER_BIT=4, NUM_REQ=3)
//  1 single: req=3'b010, data1=8'h35 -> ack=3'b010 + tx_load 1 cycle, tx_data=8'h35, grant_id=1; 10 tx_shift
//    pulses 4 cycles apart; busy high 41 cycles; capture of shifter serial output = 0,1,0,1,0,1,1,0,0,1.
//  2 contention: req=3'b111 held, data 8'h31/8'h32/8'h33 -> frames in order 0,1,2,0; LOAD-to-LOAD spacing 42 cycles.
//  3 fairness: req0 held continuously, req2 asserted mid-frame of req0 -> next grant is 2, then 0.
//  4 withdrawal/hold-off: tx_en=0 with req=3'b001 -> no ack for 20 cycles; tx_en=1 -> LOAD 2 cycles later;
//    req1 pulsed for 5 cycles during SEND then dropped -> no grant to 1.
//  5 reset mid-frame: reset_n=0 after 4th tx_shift -> all outputs 0 same cycle, busy=0; after release with
//    req=3'b100 -> grant_id=2 only if req0/req1 low (pointer reset; req0 wins if also pending).
//  6 protocol checks (assertions, all tests): onehot0(ack); ack==tx_load-gated; never tx_load&tx_shift;
//    exactly 10 tx_shift per LOAD unless reset.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART TX shifter between byte sources
//
// Several byte sources (accumulator result, RX echo, status, ...) compete for a
// single external 10-bit TX shift register. One pending requester is picked
// round-robin. Its byte is captured, and the shifter is then sequenced: one load
// pulse, followed by ten shift pulses spaced one bit period apart (start bit,
// 8 data bits LSB first, stop bit). Only one frame is in flight at a time.
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   tx_en     in   1 = new grants allowed; 0 = hold off (current frame still completes)
//   req       in   [NUM_REQ]   level request per source, held until its ack
//   req_data  in   [NUM_REQ*8] byte of source i at [8*i+7:8*i]
//   ack       out  [NUM_REQ]   one-cycle pulse, source's byte has been captured
//   tx_data   out  [8]         captured byte, stable from one load to the next
//   tx_load   out  one-cycle pulse, shifter loads {1'b1, tx_data, 1'b0}
//   tx_shift  out  one-cycle pulse at the end of each bit period, shifter shifts right
//   busy      out  high while a frame is loading or being sent
//   grant_id  out  [2] index of the source owning the current/last frame

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic                   CLOCK_50,
    input  logic                   reset_n,
    input  logic                   tx_en,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [7:0]             tx_data,
    output logic                   tx_load,
    output logic                   tx_shift,
    output logic                   busy,
    output logic [1:0]             grant_id
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        LAST_BIT  = 4'd9;
    // Pointer starts on the highest index so that source 0 wins the first grant.
    localparam logic [1:0]        PTR_INIT  = 2'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_cnt;
    logic [1:0]        last;

    logic [3:0]        req_ext;
    logic [31:0]       data_ext;
    logic              found;
    logic [1:0]        winner;
    logic [1:0]        idx;
    logic              grant;
    logic              baud_done;

    // Widen request/data to the 4-source maximum so the search below can use
    // plain 2-bit indices regardless of NUM_REQ.
    assign req_ext  = 4'(req);
    assign data_ext = 32'(req_data);

    // Round-robin search: look at last+1, last+2, ... (mod NUM_REQ); the first
    // pending source wins. The previous owner is looked at last.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = 2'((int'(last) + k) % NUM_REQ);
            if (!found && req_ext[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign grant     = (state == IDLE) && tx_en && found;
    assign baud_done = (baud_cnt == BAUD_LAST);

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and outputs. All strobes are decoded from registered state
    // so they fall to 0 as soon as reset asserts.
    always_comb begin
        state_next = state;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        busy       = 1'b0;
        ack        = '0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                tx_load    = 1'b1;
                busy       = 1'b1;
                ack        = NUM_REQ'(4'b0001 << grant_id);
                state_next = SEND;
            end
            SEND: begin
                busy     = 1'b1;
                tx_shift = baud_done;
                // The 10th shift (stop bit out) ends the frame.
                if (baud_done && (bit_cnt == LAST_BIT)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture of the winner plus baud/bit timing.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            tx_data  <= 8'h00;
            grant_id <= 2'd0;
            last     <= PTR_INIT;
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
        end else begin
            if (grant) begin
                tx_data  <= data_ext[{winner, 3'b000} +: 8];
                grant_id <= winner;
                last     <= winner;
            end
            case (state)
                LOAD: begin
                    baud_cnt <= '0;
                    bit_cnt  <= 4'd0;
                end
                SEND: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 4'd1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
